// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES key-schedule definitions: PC-1 / PC-2 permutation tables, the
// per-round left-shift table and the schedule FSM state encoding. The
// encrypt-side schedule uses the same tables.
//
// Bit numbering follows FIPS 46: table entries are 1-based bit numbers where
// bit 1 is the MSB of the vector being permuted.
// -----------------------------------------------------------------------------
package des_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // PC-1: 64-bit key -> 56-bit C||D (parity bits dropped)
    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: 56-bit C||D -> 48-bit subkey
    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Encryption left-shift amount for rounds 1..16 (index = round - 1).
    // The decrypt schedule undoes entry [n-1] when stepping from Kn to Kn-1.
    localparam int SHIFT_TABLE [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Key bit i (FIPS) sits at vector index 64-i; C||D bit j at index 56-j.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int j = 0; j < 56; j++) begin
            cd[55-j] = key[64-PC1_TABLE[j]];
        end
        return cd;
    endfunction

    // FIPS bit 1 is the MSB, so a FIPS right rotation moves bits toward the LSB.
    function automatic logic [27:0] rotr28(input logic [27:0] x, input int amt);
        return (amt == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_decrypt_key_schedule_if.sv
// -----------------------------------------------------------------------------
// des_decrypt_key_schedule_if
// Key-load and subkey-stream signals of the decrypt key schedule.
//   Key_Input[64:1]     DES key, bit 64 = FIPS key bit 1
//   Start / Abort       load key and begin / cancel a sequence
//   Key_Ready           schedule idle, Start accepted
//   Subkey_Output[48:1] current subkey (valid/ready handshake with
//   Subkey_Valid / Subkey_Ready)
//   Round_Index[3:0]    encryption round of current subkey minus 1
//   Finish_Flag         one-cycle pulse after K1 is accepted
// slave = the schedule block, master = the key source / subkey consumer.
// -----------------------------------------------------------------------------
interface des_decrypt_key_schedule_if;
    logic [64:1] Key_Input;
    logic        Start;
    logic        Abort;
    logic        Key_Ready;
    logic [48:1] Subkey_Output;
    logic        Subkey_Valid;
    logic        Subkey_Ready;
    logic [3:0]  Round_Index;
    logic        Finish_Flag;

    modport master (
        output Key_Input, Start, Abort, Subkey_Ready,
        input  Key_Ready, Subkey_Output, Subkey_Valid, Round_Index, Finish_Flag
    );

    modport slave (
        input  Key_Input, Start, Abort, Subkey_Ready,
        output Key_Ready, Subkey_Output, Subkey_Valid, Round_Index, Finish_Flag
    );
endinterface

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// Combinational PC-2 permutation: 56-bit C||D -> 48-bit subkey.
//   cd[55:0]     C||D, FIPS bit 1 at index 55
//   subkey[47:0] subkey, FIPS bit 1 at index 47
// -----------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    always_comb begin
        subkey = '0;
        for (int j = 0; j < 48; j++) begin
            subkey[47-j] = cd[56-PC2_TABLE[j]];
        end
    end

endmodule

// File: rtl/des_decrypt_key_schedule.sv
// -----------------------------------------------------------------------------
// des_decrypt_key_schedule
// Produces the 16 DES subkeys in decrypt order K16..K1 over a valid/ready
// stream. C/D are loaded unrotated from PC-1(key) (a full encrypt schedule
// rotates by 28 bits, so this is already K16) and rotated right on each
// accepted subkey.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          des_decrypt_key_schedule_if.slave (see interface header)
// CLEAR_IDLE=1 forces Subkey_Output to zero while Subkey_Valid=0; with 0 the
// output keeps showing PC-2 of the retained C/D (the last subkey).
// -----------------------------------------------------------------------------
module des_decrypt_key_schedule
    import des_pkg::*;
#(
    parameter bit CLEAR_IDLE = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    des_decrypt_key_schedule_if.slave     bus
);

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        fin_q, fin_d;
    logic [47:0] subkey_pc2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            fin_q   <= fin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        fin_d   = 1'b0;

        // Abort outranks Start and the subkey handshake
        if (bus.Abort) begin
            state_d = ST_IDLE;
            round_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.Start) begin
                        state_d    = ST_RUN;
                        {c_d, d_d} = pc1(bus.Key_Input);
                        round_d    = 4'd15;
                    end
                end
                ST_RUN: begin
                    if (bus.Subkey_Ready) begin
                        if (round_q == 4'd0) begin
                            // K1 accepted: C/D left as-is, Round_Index already 0
                            state_d = ST_IDLE;
                            fin_d   = 1'b1;
                        end else begin
                            c_d     = rotr28(c_q, SHIFT_TABLE[round_q]);
                            d_d     = rotr28(d_q, SHIFT_TABLE[round_q]);
                            round_d = round_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (subkey_pc2)
    );

    assign bus.Key_Ready     = (state_q == ST_IDLE);
    assign bus.Subkey_Valid  = (state_q == ST_RUN);
    assign bus.Round_Index   = round_q;
    assign bus.Finish_Flag   = fin_q;
    assign bus.Subkey_Output = (CLEAR_IDLE && (state_q != ST_RUN)) ? 48'd0 : subkey_pc2;

endmodule

// File: tb/tb_des_decrypt_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_des_decrypt_key_schedule
// Drives des_decrypt_key_schedule through directed and randomized sequences
// and compares every emitted subkey with a reference schedule computed
// forward (K1..K16, cumulative left shifts on bit arrays).
// -----------------------------------------------------------------------------
module tb_des_decrypt_key_schedule;

    localparam logic [63:0] VEC_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] VEC_K16 = 48'hCB3D8B0E17F5;
    localparam logic [47:0] VEC_K1  = 48'h1B02EFFC7072;

    localparam int TB_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int TB_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int TB_LS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    des_decrypt_key_schedule_if bus_if ();

    des_decrypt_key_schedule #(
        .CLEAR_IDLE (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [47:0] ref_k [1:16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Forward encryption schedule: ref_k[r] = Kr
    function automatic void build_ref(input logic [63:0] key);
        logic        c [1:28];
        logic        d [1:28];
        logic        cd [1:56];
        logic        tc, td;
        logic [47:0] k;
        for (int i = 1; i <= 28; i++) begin
            c[i] = key[64-TB_PC1[i-1]];
            d[i] = key[64-TB_PC1[i+27]];
        end
        for (int r = 1; r <= 16; r++) begin
            for (int s = 0; s < TB_LS[r-1]; s++) begin
                tc = c[1];
                td = d[1];
                for (int i = 1; i < 28; i++) begin
                    c[i] = c[i+1];
                    d[i] = d[i+1];
                end
                c[28] = tc;
                d[28] = td;
            end
            for (int i = 1; i <= 28; i++) begin
                cd[i]    = c[i];
                cd[i+28] = d[i];
            end
            k = '0;
            for (int j = 1; j <= 48; j++) k[48-j] = cd[TB_PC2[j-1]];
            ref_k[r] = k;
        end
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, bus_if.Subkey_Valid, 0);
        chk({tag, "_ready"}, bus_if.Key_Ready, 1);
        chk({tag, "_subkey"}, bus_if.Subkey_Output, 0);
        chk({tag, "_round"}, bus_if.Round_Index, 0);
    endtask

    // Start one sequence and consume it with random stalls; optionally keep
    // pulsing Start with other keys while it runs.
    task automatic run_seq(input logic [63:0] key, input int stall_pct, input bit poke,
                           output int cycles);
        int idx;
        build_ref(key);
        chk("seq_key_ready", bus_if.Key_Ready, 1);
        bus_if.Key_Input    = key;
        bus_if.Start        = 1'b1;
        bus_if.Subkey_Ready = 1'b0;
        next_cycle();
        bus_if.Start     = 1'b0;
        bus_if.Key_Input = {$urandom(), $urandom()};
        idx    = 15;
        cycles = 0;
        while (idx >= 0 && cycles < 400) begin
            chk("seq_valid", bus_if.Subkey_Valid, 1);
            chk("seq_round", bus_if.Round_Index, idx);
            chk("seq_subkey", bus_if.Subkey_Output, ref_k[idx+1]);
            chk("seq_no_fin", bus_if.Finish_Flag, 0);
            bus_if.Subkey_Ready = ($urandom_range(99) >= stall_pct);
            if (poke) begin
                bus_if.Start     = $urandom_range(1);
                bus_if.Key_Input = {$urandom(), $urandom()};
            end
            if (bus_if.Subkey_Ready) idx--;
            next_cycle();
            cycles++;
        end
        bus_if.Start        = 1'b0;
        bus_if.Subkey_Ready = 1'b0;
        if (idx >= 0) chk("seq_timeout", idx, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("seq_fin", bus_if.Finish_Flag, 1);
        check_idle("seq_end");
        next_cycle();
        chk("seq_fin_pulse", bus_if.Finish_Flag, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int fin_seen;
        int budget;

        bus_if.Key_Input    = '0;
        bus_if.Start        = 1'b0;
        bus_if.Abort        = 1'b0;
        bus_if.Subkey_Ready = 1'b0;

        // Reset
        #2 rst_n = 1'b0;
        #1;
        check_idle("rst");
        chk("rst_fin", bus_if.Finish_Flag, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        next_cycle();
        check_idle("post_rst");

        // Known vector, consumer always ready
        build_ref(VEC_KEY);
        bus_if.Key_Input    = VEC_KEY;
        bus_if.Start        = 1'b1;
        bus_if.Subkey_Ready = 1'b1;
        next_cycle();
        bus_if.Start = 1'b0;
        chk("vec_t1_valid", bus_if.Subkey_Valid, 1);
        chk("vec_t1_k16", bus_if.Subkey_Output, VEC_K16);
        chk("vec_t1_round", bus_if.Round_Index, 15);
        chk("vec_t1_keyready", bus_if.Key_Ready, 0);
        repeat (15) next_cycle();
        chk("vec_t16_k1", bus_if.Subkey_Output, VEC_K1);
        chk("vec_t16_round", bus_if.Round_Index, 0);
        chk("vec_t16_fin", bus_if.Finish_Flag, 0);
        next_cycle();
        chk("vec_t17_fin", bus_if.Finish_Flag, 1);
        check_idle("vec_t17");
        bus_if.Subkey_Ready = 1'b0;
        next_cycle();
        chk("vec_t18_fin", bus_if.Finish_Flag, 0);

        // Known vector, 5-cycle stall on K16
        bus_if.Key_Input = VEC_KEY;
        bus_if.Start     = 1'b1;
        next_cycle();
        bus_if.Start     = 1'b0;
        bus_if.Key_Input = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 5; i++) begin
            chk("stall_k16", bus_if.Subkey_Output, VEC_K16);
            chk("stall_round", bus_if.Round_Index, 15);
            next_cycle();
        end
        bus_if.Subkey_Ready = 1'b1;
        for (int n = 15; n >= 0; n--) begin
            chk("stall_seq_round", bus_if.Round_Index, n);
            chk("stall_seq_subkey", bus_if.Subkey_Output, ref_k[n+1]);
            next_cycle();
        end
        chk("stall_fin", bus_if.Finish_Flag, 1);
        bus_if.Subkey_Ready = 1'b0;
        next_cycle();

        // Abort at Round_Index 7
        bus_if.Key_Input    = VEC_KEY;
        bus_if.Start        = 1'b1;
        bus_if.Subkey_Ready = 1'b1;
        next_cycle();
        bus_if.Start = 1'b0;
        budget = 0;
        while (bus_if.Round_Index != 4'd7 && budget < 40) begin
            next_cycle();
            budget++;
        end
        chk("abort_reach_r7", bus_if.Round_Index, 7);
        bus_if.Abort = 1'b1;
        next_cycle();
        bus_if.Abort        = 1'b0;
        bus_if.Subkey_Ready = 1'b0;
        check_idle("abort");
        fin_seen = int'(bus_if.Finish_Flag);
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            fin_seen += int'(bus_if.Finish_Flag);
        end
        chk("abort_no_fin", fin_seen, 0);

        // Abort outranks Start in IDLE
        bus_if.Start = 1'b1;
        bus_if.Abort = 1'b1;
        next_cycle();
        bus_if.Start = 1'b0;
        bus_if.Abort = 1'b0;
        check_idle("abort_start");

        // Restart after abort begins at K16
        bus_if.Start        = 1'b1;
        bus_if.Subkey_Ready = 1'b1;
        next_cycle();
        bus_if.Start = 1'b0;
        chk("restart_k16", bus_if.Subkey_Output, VEC_K16);
        chk("restart_round", bus_if.Round_Index, 15);
        repeat (16) next_cycle();
        chk("restart_fin", bus_if.Finish_Flag, 1);
        bus_if.Subkey_Ready = 1'b0;
        next_cycle();

        // Asynchronous reset mid-sequence
        bus_if.Key_Input    = {$urandom(), $urandom()};
        bus_if.Start        = 1'b1;
        bus_if.Subkey_Ready = 1'b1;
        next_cycle();
        bus_if.Start = 1'b0;
        repeat (3) next_cycle();
        #3 rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        chk("async_rst_fin", bus_if.Finish_Flag, 0);
        @(negedge clk) rst_n = 1'b1;
        fin_seen = 0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            fin_seen += int'(bus_if.Finish_Flag);
        end
        chk("async_rst_no_fin", fin_seen, 0);
        bus_if.Subkey_Ready = 1'b0;
        run_seq({$urandom(), $urandom()}, 0, 1'b0, cyc);
        chk("post_rst_seq_cycles", cyc, 16);

        // Start with other keys while running is ignored
        run_seq({$urandom(), $urandom()}, 30, 1'b1, cyc);

        // Random keys with random stalls
        for (int t = 0; t < 8; t++) begin
            run_seq({$urandom(), $urandom()}, 40, 1'b0, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/des_decrypt_key_schedule.md
DES_DECRYPT_KEY_SCHEDULE -- requirements
Module: des_decrypt_key_schedule

Interface
REQ-001 Parameter: CLEAR_IDLE, default 1, drives Subkey_Output to all-zeros whenever Subkey_Valid=0; when 0, holds the last value.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Key_Input  input  64 [64:1]  DES key, FIPS 46 bit numbering (bit 64 = key bit 1); parity bits ignored.
REQ-005 Start  input  1  load Key_Input and begin a 16-subkey decrypt sequence.
REQ-006 Abort  input  1  cancel the sequence in progress.
REQ-007 Subkey_Ready  input  1  consumer accepts the current subkey.
REQ-008 Key_Ready  output  1  block is idle and accepts Start.
REQ-009 Subkey_Output  output  48 [48:1]  current subkey, PC-2 ordering.
REQ-010 Subkey_Valid  output  1  Subkey_Output is valid.
REQ-011 Round_Index  output  4  encryption round number of the current subkey minus 1: 15 down to 0.
REQ-012 Finish_Flag  output  1  one-cycle pulse after the final subkey (K1) is accepted.

Function
REQ-013 Subkeys SHALL be emitted in decrypt order K16, K15, ..., K1, bit-identical to the FIPS 46 encryption subkeys.
REQ-014 FSM states: IDLE and RUN only.
REQ-015 IDLE: Key_Ready=1 and Subkey_Valid=0; Start=1 with Abort=0 -> RUN.
REQ-016 On entry to RUN, the block loads C/D (28b each) from PC-1(Key_Input) unrotated, which yields K16.
REQ-017 Latency: Start accepted in cycle t -> Subkey_Valid=1 with K16 and Round_Index=15 in cycle t+1.
REQ-018 Handshake: Subkey_Output and Round_Index SHALL hold stable while Subkey_Valid=1 and Subkey_Ready=0.
REQ-019 On Subkey_Valid&&Subkey_Ready, C/D rotate right and the next subkey appears the following cycle.
REQ-020 Right-rotate amount per step (transition from emitted subkey Kn to Kn-1): n=16 -> 1; n=15..10 -> 2; n=9 -> 1; n=8..3 -> 2; n=2 -> 1.
REQ-021 When K1 (Round_Index=0) is accepted: -> IDLE; Finish_Flag=1 and Key_Ready=1 in the next cycle; no rotation occurs.
REQ-022 Subkey_Ready=1 continuously: one subkey per cycle; K1 is accepted in cycle t+16; Finish_Flag is asserted in cycle t+17.
REQ-023 Start is ignored while in RUN; Key_Input is sampled only on the accepting cycle.
REQ-024 Abort=1 in any state -> IDLE next cycle, Subkey_Valid=0, no Finish_Flag; Abort outranks Start and handshake.
REQ-025 Subkey_Output = PC-2(C,D), a combinational function of registered C/D; no path from Key_Input to any output.
REQ-026 Round_Index SHALL read 0 in IDLE.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, C/D=0, Round_Index=0, Subkey_Valid=0, Finish_Flag=0, Key_Ready=1, Subkey_Output=0.
REQ-028 Reset mid-sequence discards the sequence with no Finish_Flag; the first Start after reset release behaves per REQ-017.

Structure
REQ-029 Shared package des_pkg holds the PC-1 and PC-2 tables, the 16-entry shift table, and the state encoding; the encrypt-side schedule reuses them.
REQ-030 One sub-module, des_pc2 (combinational 56->48 permutation), is instantiated once.

Verification
REQ-031 Key 0x133457799BBCDFF1, Start, Subkey_Ready=1 -> cycle t+1 Subkey_Output=0xCB3D8B0E17F5 (Round_Index=15); cycle t+16 Subkey_Output=0x1B02EFFC7072 (Round_Index=0); Finish_Flag at t+17.
REQ-032 Same key, Subkey_Ready held 0 for 5 cycles after K16 -> output stable at 0xCB3D8B0E17F5, Round_Index=15; resume -> sequence unchanged.
REQ-033 Abort asserted when Round_Index=7 -> Subkey_Valid=0 and Key_Ready=1 next cycle, Finish_Flag never pulses; a new Start restarts at K16.
REQ-034 rst_n pulsed low mid-sequence (asynchronous, between edges) -> outputs at reset values immediately.
REQ-035 Start pulsed during RUN with a different key -> ignored; all 16 subkeys match the first key.
REQ-036 Random keys, random Subkey_Ready stalls -> 16 subkeys match a reference model's K16..K1, each emitted exactly once.
